// File: rtl/dmem_pkg.sv
// Shared width encodings, arbiter state type and access legality rule for the data-memory arbiter.
package dmem_pkg;

  localparam logic [2:0] WIDTH_B  = 3'b000;
  localparam logic [2:0] WIDTH_H  = 3'b001;
  localparam logic [2:0] WIDTH_W  = 3'b010;
  localparam logic [2:0] WIDTH_BU = 3'b011;
  localparam logic [2:0] WIDTH_HU = 3'b100;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Halfwords need even addresses, words need 4-byte alignment, 101..111 never legal.
  function automatic logic is_legal(input logic [2:0] width, input logic [1:0] addr_lo);
    case (width)
      WIDTH_B, WIDTH_BU: is_legal = 1'b1;
      WIDTH_H, WIDTH_HU: is_legal = ~addr_lo[0];
      WIDTH_W:           is_legal = (addr_lo == 2'b00);
      default:           is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request fields in, zero-cycle grant and
// one-cycle registered response out.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 9
);
  logic              req;
  logic              we;
  logic [2:0]        width;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              err;

  modport master (output req, we, width, addr, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, width, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dmem_resp_reg.sv
// Per-port response register: captures rvalid/err/rdata on the grant cycle, presents them one cycle later.
module dmem_resp_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        gnt,
  input  logic        we,
  input  logic        legal,
  input  logic [31:0] mem_rdata,
  output logic        rvalid,
  output logic        err,
  output logic [31:0] rdata
);

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= gnt;
      err    <= gnt & ~legal;
      rdata  <= (gnt & ~we & legal) ? mem_rdata : '0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Fixed-priority two-port arbiter for the single-port data memory with starvation guard and port-1 lock.
// Grant is combinational in the request cycle; response registered one cycle later; losers simply hold req.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  input  logic              m1_lock,
  output logic              mem_we,
  output logic              mem_re,
  output logic [2:0]        mem_width_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  arb_state_t        state_q, state_d;
  logic [3:0]        wait_cnt_q;
  logic              gnt0, gnt1, any_gnt;
  logic              sel_we, legal;
  logic [2:0]        sel_width;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;

  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
    if (!rst) begin
      case (state_q)
        ARB: begin
          if (m1.req && (!m0.req || wait_cnt_q == 4'(MAX_WAIT))) begin
            gnt1 = 1'b1;
          end else if (m0.req) begin
            gnt0 = 1'b1;
          end
          if (gnt1 && m1_lock) state_d = LOCKED;
        end
        LOCKED: begin
          // Port 0 is shut out; release only when port 1 drops the lock.
          gnt1 = m1.req;
          if (!m1_lock) state_d = ARB;
        end
        default: state_d = ARB;
      endcase
    end
  end

  assign m0.gnt  = gnt0;
  assign m1.gnt  = gnt1;
  assign any_gnt = gnt0 | gnt1;

  assign sel_we    = gnt1 ? m1.we    : m0.we;
  assign sel_width = gnt1 ? m1.width : m0.width;
  assign sel_addr  = gnt1 ? m1.addr  : m0.addr;
  assign sel_wdata = gnt1 ? m1.wdata : m0.wdata;
  assign legal     = is_legal(sel_width, sel_addr[1:0]);

  assign mem_re        = any_gnt & ~sel_we & legal;
  assign mem_we        = any_gnt &  sel_we & legal;
  assign mem_width_sel = any_gnt ? sel_width : '0;
  assign mem_addr      = any_gnt ? sel_addr  : '0;
  assign mem_wdata     = any_gnt ? sel_wdata : '0;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ARB;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst || !m1.req || gnt1) begin
      wait_cnt_q <= '0;
    end else if (wait_cnt_q != 4'(MAX_WAIT)) begin
      wait_cnt_q <= wait_cnt_q + 4'd1;
    end
  end

  dmem_resp_reg u_resp0 (
    .clk       (clk),
    .rst       (rst),
    .gnt       (gnt0),
    .we        (sel_we),
    .legal     (legal),
    .mem_rdata (mem_rdata),
    .rvalid    (m0.rvalid),
    .err       (m0.err),
    .rdata     (m0.rdata)
  );

  dmem_resp_reg u_resp1 (
    .clk       (clk),
    .rst       (rst),
    .gnt       (gnt1),
    .we        (sel_we),
    .legal     (legal),
    .mem_rdata (mem_rdata),
    .rvalid    (m1.rvalid),
    .err       (m1.err),
    .rdata     (m1.rdata)
  );

endmodule
